// File: rtl/countdown_timer.sv
// countdown_timer
// Loadable down-counter with a start/busy/done handshake.
//
// Handshake: a request is a cycle with start=1 while the block is IDLE
// (clr=0); it is accepted on that rising edge and load_val is captured at
// the same edge. busy is high for every cycle the block is counting (RUN),
// and done is high for exactly one cycle (DONE) when the count reaches
// zero. start is ignored outside IDLE, and clr overrides everything.
//
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN
//   Undefined: single-shot operation, DONE always returns to IDLE.
//   Defined:   an accepted start also latches load_val as a period P. While
//              P is non-zero, DONE reloads q with P and re-enters RUN, so the
//              block produces a done pulse every P+1 enabled cycles until
//              clr is asserted. P is cleared by clr.

module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;

    // A start in IDLE is the only way a new count can begin.
    logic             start_acc;
    // RUN finishes on the enabled 1 -> 0 step, so q never wraps.
    logic             last_step;
    // DONE either re-enters RUN (periodic mode) or falls back to IDLE.
    logic             reload;
    logic [WIDTH-1:0] reload_val;

    assign start_acc = (state == ST_IDLE) && start;
    assign last_step = (state == ST_RUN) && en && (q == ONE);

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [WIDTH-1:0] period;

    // Period register: captured with every accepted start, cleared by clr.
    always_ff @(posedge clk) begin
        if (clr) begin
            period <= ZERO_VAL;
        end else if (start_acc) begin
            period <= load_val;
        end
    end

    assign reload     = (state == ST_DONE) && (period != ZERO_VAL);
    assign reload_val = period;
`else
    assign reload     = 1'b0;
    assign reload_val = ZERO_VAL;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    // A zero load has nothing to count, so skip RUN.
                    state_nxt = (load_val == ZERO_VAL) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = reload ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode: busy and done come straight from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            ST_RUN:  busy = 1'b1;
            ST_DONE: done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Next count value: load, decrement, reload or hold.
    always_comb begin
        q_nxt = q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    q_nxt = load_val;
                end
            end
            ST_RUN: begin
                if (en) begin
                    q_nxt = q - ONE;
                end
            end
            ST_DONE: begin
                if (reload) begin
                    q_nxt = reload_val;
                end
            end
            default: begin
                q_nxt = ZERO_VAL;
            end
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= ZERO_VAL;
        end else begin
            q <= q_nxt;
        end
    end

    assign zero      = (q == ZERO_VAL);
    assign dbg_state = state;

    // Sanity properties on the handshake outputs and the count.
    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (!(busy && done))
                else $error("busy and done high together");
            assert (state != ST_DONE || q == ZERO_VAL)
                else $error("q not zero in DONE");
            assert (state != ST_RUN || q != ZERO_VAL)
                else $error("q zero in RUN");
        end
    end

    // Reject unsupported widths at elaboration.
    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("countdown_timer: WIDTH must be in 2..16");
        end
    endgenerate

endmodule
